// File: rtl/seq_bitlen_decoder_if.sv
// Start/done handshake bundle for seq_bitlen_decoder.
// master: requester side (drives start/value); slave: the decoder.
interface seq_bitlen_decoder_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 8
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [CW-1:0]    y;
    logic             is_pow2;
    logic [WIDTH-1:0] x;

    modport master (
        output start, value,
        input  busy, done, y, is_pow2, x
    );

    modport slave (
        input  start, value,
        output busy, done, y, is_pow2, x
    );
endinterface

// File: rtl/seq_bitlen_decoder.sv
// Iterative bit-length decoder: shifts the captured value right one bit per
// clock until it is zero, counting shifts (y) and tracking whether exactly one
// set bit was seen (is_pow2).
// Optional macro SEQ_BITLEN_REPEAT_EN builds a REPEAT state that regenerates
// x = 2**y (mod 2**WIDTH) by repeated left shift; without it x is constant 0.
module seq_bitlen_decoder #(
    parameter int WIDTH = 32,
    parameter int CW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_bitlen_decoder_if.slave    bus
);

`ifdef SEQ_BITLEN_REPEAT_EN
    typedef enum logic [1:0] {IDLE, SHIFT, REPEAT, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [1:0]       ones;     // saturating count of set bits: 0, 1, 2+
    logic [CW-1:0]    y_q;
    logic             pow2_q;
`ifdef SEQ_BITLEN_REPEAT_EN
    logic [WIDTH-1:0] xreg;
    logic [CW-1:0]    rep;
    logic [WIDTH-1:0] x_q;
`endif

    // State register; rst aborts any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a
        // signal unassigned and infers a latch.
        state_nxt = state;
        bus.busy  = (state != IDLE);
        bus.done  = (state == DONE);
        unique case (state)
            IDLE:  if (bus.start) state_nxt = SHIFT;
            SHIFT: begin
                if (sreg == '0) begin
`ifdef SEQ_BITLEN_REPEAT_EN
                    state_nxt = REPEAT;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef SEQ_BITLEN_REPEAT_EN
            REPEAT: if (rep == '0) state_nxt = DONE;
`endif
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, shift/count, result latching, optional 2**y rebuild.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg   <= '0;
            cnt    <= '0;
            ones   <= '0;
            y_q    <= '0;
            pow2_q <= 1'b0;
`ifdef SEQ_BITLEN_REPEAT_EN
            xreg   <= '0;
            rep    <= '0;
            x_q    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sreg <= bus.value;
                        cnt  <= '0;
                        ones <= '0;
                    end
                end
                SHIFT: begin
                    if (sreg == '0) begin
                        y_q    <= cnt;
                        pow2_q <= (ones == 2'd1);
`ifdef SEQ_BITLEN_REPEAT_EN
                        xreg   <= WIDTH'(1);
                        rep    <= cnt;
`endif
                    end else begin
                        sreg <= sreg >> 1;
                        cnt  <= cnt + 1'b1;
                        if (sreg[0] && ones != 2'd2) ones <= ones + 2'd1;
                    end
                end
`ifdef SEQ_BITLEN_REPEAT_EN
                REPEAT: begin
                    if (rep == '0) begin
                        x_q <= xreg;
                    end else begin
                        xreg <= xreg << 1;   // bits past WIDTH-1 fall off
                        rep  <= rep - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.y       = y_q;
    assign bus.is_pow2 = pow2_q;
`ifdef SEQ_BITLEN_REPEAT_EN
    assign bus.x       = x_q;
`else
    assign bus.x       = '0;
`endif

endmodule

// File: tb/tb_seq_bitlen_decoder.sv
// Self-checking bench for seq_bitlen_decoder: directed corner cases plus
// randomized operands, compared against a behavioural model of bit-length,
// power-of-two flag, 2**y and handshake latency.
module tb_seq_bitlen_decoder;

    localparam int WIDTH = 32;
    localparam int CW    = 8;
`ifdef SEQ_BITLEN_REPEAT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [CW-1:0] prev_y;

    seq_bitlen_decoder_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    seq_bitlen_decoder #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic int ref_bitlen(input logic [WIDTH-1:0] v);
        int bl = 0;
        for (int i = 0; i < WIDTH; i++) if (v[i]) bl = i + 1;
        return bl;
    endfunction

    function automatic logic [63:0] ref_x(input int bl);
        logic [63:0] p;
        if (!FEAT) return 64'd0;
        p = 64'd1 << bl;
        return p & 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Edges from the capturing edge to the edge that first samples done=1.
    function automatic int ref_latency(input int bl);
        return FEAT ? (2 * bl + 3) : (bl + 2);
    endfunction

    // One complete operation from IDLE, with all result checks.
    task automatic do_op(input logic [WIDTH-1:0] v);
        int k;
        bit seen;
        int bl;
        bl = ref_bitlen(v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = v;
        @(posedge clk);                  // capture edge
        @(negedge clk);
        bus.start = 1'b0;
        bus.value = $urandom;            // must not disturb the captured operand
        check("busy_after_start", bus.busy, 1);
        check("y_holds_prev", bus.y, prev_y);
        k = 0;
        seen = 0;
        while (!seen && k < 200) begin
            if (bus.done) seen = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("done_seen", seen, 1);
        if (seen) begin
            check("latency", k + 1, ref_latency(bl));
            check("busy_in_done", bus.busy, 1);
            check("y", bus.y, bl);
            check("is_pow2", bus.is_pow2, ($countones(v) == 1));
            check("x", bus.x, ref_x(bl));
            @(negedge clk);
            check("done_one_cycle", bus.done, 0);
            check("idle_after_done", bus.busy, 0);
            prev_y = CW'(bl);
        end
    endtask

    initial begin
        int dcount;
        int k;
        bit seen;
        n_checks  = 0;
        n_errors  = 0;
        prev_y    = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_y", bus.y, 0);
        check("rst_pow2", bus.is_pow2, 0);
        check("rst_x", bus.x, 0);

        // Directed corner cases.
        do_op(32'd0);
        do_op(32'd1);
        do_op(32'd40);
        do_op(32'h8000_0000);
        do_op(32'hFFFF_FFFF);

        // Second start while busy is dropped.
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 32'd255;
        @(negedge clk);
        bus.start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done) dcount++;
            @(negedge clk);
        end
        check("overlap_single_done", dcount, 1);
        check("overlap_y", bus.y, 3);
        check("overlap_pow2", bus.is_pow2, 0);
        check("overlap_idle", bus.busy, 0);
        prev_y = 3;

        // Start held high: next capture on the first IDLE edge after DONE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 32'd6;
        k = 0;
        seen = 0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (bus.done) seen = 1;
        end
        check("b2b_first_done", seen, 1);
        k = 0;
        seen = 0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (bus.done) seen = 1;
        end
        bus.start = 1'b0;
        check("b2b_second_done", seen, 1);
        check("b2b_gap", k, FEAT ? (2 * 3 + 4) : (3 + 3));
        check("b2b_y", bus.y, 3);
        @(negedge clk);
        check("b2b_idle", bus.busy, 0);
        prev_y = 3;

        // Randomized operands with a spread of bit-lengths.
        for (int n = 0; n < 25; n++) begin
            logic [WIDTH-1:0] v;
            v = WIDTH'($urandom) >> $urandom_range(0, WIDTH);
            do_op(v);
        end

        // Reset during SHIFT aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 32'hFFFF_FFFF;
        @(posedge clk);                  // capture edge t
        dcount = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) dcount++;
        end
        rst = 1'b1;                      // sampled at edge t+10
        @(negedge clk);
        rst = 1'b0;
        check("abort_no_done", dcount, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_y", bus.y, 0);
        check("abort_pow2", bus.is_pow2, 0);
        check("abort_x", bus.x, 0);
        prev_y = '0;
        do_op(32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
